// File: rtl/arb_pkg.sv
// Shared defaults, parameter legality check and the round-robin search used by
// the weighted bid arbiter and its per-requester accounts.
package arb_pkg;

    localparam int DEF_N             = 4;
    localparam int DEF_BID_W         = 4;
    localparam int DEF_BAL_W         = 10;
    localparam int DEF_BAL_INIT      = 750;
    localparam int DEF_BAL_MAX       = 900;
    localparam int DEF_REFILL_AMT    = 750;
    localparam int DEF_REFILL_PERIOD = 400;
    localparam int DEF_STARVE_LIMIT  = 60;

    function automatic logic arb_params_ok(
        input int n,
        input int bal_w,
        input int bal_max,
        input int refill_amt,
        input int refill_period,
        input int starve_limit
    );
        logic [63:0] bal_span;
        bal_span = 64'd1 << bal_w;
        return (n >= 2) && (n <= 16) &&
               (64'(bal_max) < bal_span) && (64'(refill_amt) < bal_span) &&
               (refill_period >= 2) && (starve_limit >= 1);
    endfunction

    // Returns {found, index}: first set bit of mask searching upward from ptr+1, wrapping at n.
    function automatic logic [4:0] rr_first(
        input logic [15:0] mask,
        input logic [3:0]  ptr,
        input int          n
    );
        logic [4:0] res;
        logic [4:0] idx;
        res = 5'd0;
        for (int k = 16; k >= 1; k--) begin
            if (k <= n) begin
                idx = {1'b0, ptr} + 5'(k);
                if (idx >= 5'(n)) begin
                    idx = idx - 5'(n);
                end else begin
                    idx = idx;
                end
                if (mask[idx[3:0]]) begin
                    res = {1'b1, idx[3:0]};
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bid_account.sv
// One requester's credit account: balance with floor/saturation, wait counter
// and the starved flag derived from it.
module bid_account
    import arb_pkg::*;
#(
    parameter int BID_W        = DEF_BID_W,
    parameter int BAL_W        = DEF_BAL_W,
    parameter int BAL_INIT     = DEF_BAL_INIT,
    parameter int BAL_MAX      = DEF_BAL_MAX,
    parameter int REFILL_AMT   = DEF_REFILL_AMT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             granted_i,
    input  logic [BID_W-1:0] bid_i,
    input  logic             refill_i,
    output logic [BAL_W-1:0] balance_o,
    output logic             req_o,
    output logic             elig_o,
    output logic             starved_o
);

    localparam int XW     = BAL_W + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
    localparam logic [XW-1:0]     REFILL_X = XW'(REFILL_AMT);
    localparam logic [XW-1:0]     MAX_X    = XW'(BAL_MAX);

    logic [BAL_W-1:0]  bal_q, bal_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [XW-1:0]     bal_x_s, bid_x_s, spent_s, refilled_s;

    assign bal_x_s   = {1'b0, bal_q};
    assign bid_x_s   = XW'(bid_i);
    assign req_o     = (bid_i != {BID_W{1'b0}});
    assign elig_o    = req_o && (bal_x_s >= bid_x_s);
    assign starved_o = (wait_q == WAIT_MAX);
    assign balance_o = bal_q;

    // Next balance (spend floored at zero, then refill clamped) and next wait count.
    always_comb begin
        if (granted_i) begin
            if (bal_x_s >= bid_x_s) begin
                spent_s = bal_x_s - bid_x_s;
            end else begin
                spent_s = {XW{1'b0}};
            end
        end else begin
            spent_s = bal_x_s;
        end
        refilled_s = spent_s + REFILL_X;
        if (!refill_i) begin
            bal_d = spent_s[BAL_W-1:0];
        end else if (refilled_s > MAX_X) begin
            bal_d = MAX_X[BAL_W-1:0];
        end else begin
            bal_d = refilled_s[BAL_W-1:0];
        end
        if (granted_i || !req_o) begin
            wait_d = {WAIT_W{1'b0}};
        end else if (wait_q == WAIT_MAX) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Account state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bal_q  <= BAL_W'(BAL_INIT);
            wait_q <= {WAIT_W{1'b0}};
        end else begin
            bal_q  <= bal_d;
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/weighted_bid_arbiter.sv
// N-requester credit-weighted bid arbiter: forced grants for starved requesters,
// otherwise highest affordable bid with round-robin tie-break; registered one-hot grant.
module weighted_bid_arbiter
    import arb_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int BID_W         = DEF_BID_W,
    parameter int BAL_W         = DEF_BAL_W,
    parameter int BAL_INIT      = DEF_BAL_INIT,
    parameter int BAL_MAX       = DEF_BAL_MAX,
    parameter int REFILL_AMT    = DEF_REFILL_AMT,
    parameter int REFILL_PERIOD = DEF_REFILL_PERIOD,
    parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*BID_W-1:0]     bid,
    output logic [N-1:0]           grant,
    output logic                   grant_valid,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic [N*BAL_W-1:0]     balance,
    output logic [N-1:0]           starved
);

    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(REFILL_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFILL_PERIOD - 1);
    localparam logic PARAMS_OK = arb_params_ok(N, BAL_W, BAL_MAX, REFILL_AMT,
                                               REFILL_PERIOD, STARVE_LIMIT);

    if (!PARAMS_OK) begin : g_param_check
        $error("weighted_bid_arbiter: illegal parameter set");
    end

    logic [BID_W-1:0] bid_s [N];
    logic [BAL_W-1:0] bal_s [N];
    logic [N-1:0]     req_s, elig_s, starved_s, forced_s, top_s;
    logic [N-1:0]     grant_d, grant_q;
    logic [BID_W-1:0] max_bid_s;
    logic [4:0]       pick_s;
    logic [ID_W-1:0]  ptr_d, ptr_q, grant_id_d, grant_id_q;
    logic             grant_valid_q, refill_s;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    for (genvar i = 0; i < N; i++) begin : g_acct
        assign bid_s[i] = bid[i*BID_W +: BID_W];
        bid_account #(
            .BID_W        (BID_W),
            .BAL_W        (BAL_W),
            .BAL_INIT     (BAL_INIT),
            .BAL_MAX      (BAL_MAX),
            .REFILL_AMT   (REFILL_AMT),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_acct (
            .clk       (clk),
            .rst       (rst),
            .granted_i (grant_d[i]),
            .bid_i     (bid_s[i]),
            .refill_i  (refill_s),
            .balance_o (bal_s[i]),
            .req_o     (req_s[i]),
            .elig_o    (elig_s[i]),
            .starved_o (starved_s[i])
        );
        assign balance[i*BAL_W +: BAL_W] = bal_s[i];
    end

    assign refill_s = (cnt_q == CNT_LAST);

    // Grant decision: starved requesters first, else the top affordable bid.
    always_comb begin
        forced_s  = req_s & starved_s;
        max_bid_s = {BID_W{1'b0}};
        top_s     = {N{1'b0}};
        grant_d   = {N{1'b0}};
        ptr_d     = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (elig_s[i] && (bid_s[i] > max_bid_s)) begin
                max_bid_s = bid_s[i];
            end else begin
                max_bid_s = max_bid_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            top_s[i] = elig_s[i] && (bid_s[i] == max_bid_s);
        end
        if (|forced_s) begin
            pick_s = rr_first(16'(forced_s), 4'(ptr_q), N);
        end else begin
            pick_s = rr_first(16'(top_s), 4'(ptr_q), N);
        end
        for (int i = 0; i < N; i++) begin
            grant_d[i] = pick_s[4] && (pick_s[3:0] == 4'(i));
        end
        if (pick_s[4]) begin
            ptr_d      = ID_W'(pick_s[3:0]);
            grant_id_d = ID_W'(pick_s[3:0]);
        end else begin
            grant_id_d = {ID_W{1'b0}};
        end
        if (refill_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output, pointer and refill counter registers; pointer resets so requester 0 leads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q       <= {N{1'b0}};
            grant_valid_q <= 1'b0;
            grant_id_q    <= {ID_W{1'b0}};
            ptr_q         <= ID_W'(N - 1);
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign starved     = starved_s;

endmodule

// File: tb/tb_weighted_bid_arbiter.sv
// Bench for weighted_bid_arbiter: per-cycle reference model feeding a scoreboard,
// a hand-computed vector table, and directed multi-cycle sequences.
module tb_weighted_bid_arbiter;

    localparam int N             = 4;
    localparam int BID_W         = 4;
    localparam int BAL_W         = 10;
    localparam int BAL_INIT      = 750;
    localparam int BAL_MAX       = 900;
    localparam int REFILL_AMT    = 750;
    localparam int REFILL_PERIOD = 400;
    localparam int STARVE_LIMIT  = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bid;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [39:0] balance;
    logic [3:0]  starved;

    always #5 clk = ~clk;

    weighted_bid_arbiter #(
        .N(N), .BID_W(BID_W), .BAL_W(BAL_W), .BAL_INIT(BAL_INIT), .BAL_MAX(BAL_MAX),
        .REFILL_AMT(REFILL_AMT), .REFILL_PERIOD(REFILL_PERIOD), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .bid(bid), .grant(grant), .grant_valid(grant_valid),
        .grant_id(grant_id), .balance(balance), .starved(starved)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  id;
        logic        valid;
        logic [39:0] bal;
        logic [3:0]  starved;
    } exp_t;

    typedef struct {
        logic [15:0] bid;
        logic [3:0]  exp_grant;
        logic [9:0]  exp_bal1;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_bal[N];
    int   m_wait[N];
    int   m_ptr;
    int   m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] bal_of(input int i);
        return balance[i*BAL_W +: BAL_W];
    endfunction

    task automatic model_reset(output exp_t e);
        for (int i = 0; i < N; i++) begin
            m_bal[i]  = BAL_INIT;
            m_wait[i] = 0;
        end
        m_ptr = N - 1;
        m_cnt = 0;
        e.grant   = 4'd0;
        e.id      = 2'd0;
        e.valid   = 1'b0;
        e.bal     = {4{10'd750}};
        e.starved = 4'd0;
    endtask

    task automatic model_step(input logic [15:0] bv, output exp_t e);
        int b[N];
        logic [N-1:0] req, elig, forced, cand;
        int maxb, g, nb, idx;
        for (int i = 0; i < N; i++) begin
            b[i]      = int'(bv[i*BID_W +: BID_W]);
            req[i]    = (b[i] != 0);
            elig[i]   = req[i] && (m_bal[i] >= b[i]);
            forced[i] = req[i] && (m_wait[i] == STARVE_LIMIT);
        end
        maxb = 0;
        for (int i = 0; i < N; i++) if (elig[i] && b[i] > maxb) maxb = b[i];
        for (int i = 0; i < N; i++) cand[i] = (forced != 0) ? forced[i] : (elig[i] && b[i] == maxb);
        g = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && cand[idx]) g = idx;
        end
        for (int i = 0; i < N; i++) begin
            nb = m_bal[i];
            if (g == i) nb = (nb >= b[i]) ? nb - b[i] : 0;
            if (m_cnt == REFILL_PERIOD - 1) nb = (nb + REFILL_AMT > BAL_MAX) ? BAL_MAX : nb + REFILL_AMT;
            m_bal[i] = nb;
            if (g == i || !req[i]) m_wait[i] = 0;
            else if (m_wait[i] < STARVE_LIMIT) m_wait[i]++;
        end
        m_cnt = (m_cnt == REFILL_PERIOD - 1) ? 0 : m_cnt + 1;
        if (g >= 0) m_ptr = g;
        e.grant = (g >= 0) ? 4'(4'd1 << g) : 4'd0;
        e.id    = (g >= 0) ? 2'(g) : 2'd0;
        e.valid = (g >= 0);
        for (int i = 0; i < N; i++) begin
            e.bal[i*BAL_W +: BAL_W] = 10'(m_bal[i]);
            e.starved[i]            = (m_wait[i] == STARVE_LIMIT);
        end
    endtask

    // Drive one cycle, queue the model's expectation, and compare after the edge.
    task automatic step(input logic rst_v, input logic [15:0] bid_v);
        exp_t e;
        rst = rst_v;
        bid = bid_v;
        if (!rst_v) model_reset(e);
        else model_step(bid_v, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("grant",       64'(grant),       64'(e.grant));
        check("grant_id",    64'(grant_id),    64'(e.id));
        check("grant_valid", 64'(grant_valid), 64'(e.valid));
        check("balance",     64'(balance),     64'(e.bal));
        check("starved",     64'(starved),     64'(e.starved));
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{16'h0395, 4'b0010, 10'd741};
        tbl[1] = '{16'h0395, 4'b0010, 10'd732};
        tbl[2] = '{16'h0395, 4'b0010, 10'd723};
        tbl[3] = '{16'h0000, 4'b0000, 10'd723};
        tbl[4] = '{16'h0300, 4'b0100, 10'd723};
        tbl[5] = '{16'h0395, 4'b0010, 10'd714};

        rst = 1'b0;
        bid = 16'h0000;

        // Reset state and basic highest-bid vectors.
        step(1'b0, 16'h0000);
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_bal",   64'(balance), 64'({4{10'd750}}));
        for (int v = 0; v < 6; v++) begin
            step(1'b1, tbl[v].bid);
            check("tbl_grant", 64'(grant), 64'(tbl[v].exp_grant));
            check("tbl_bal1",  64'(bal_of(1)), 64'(tbl[v].exp_bal1));
        end

        // Equal bids rotate round-robin starting at requester 0.
        step(1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'h7777);
            check("rr_id", 64'(grant_id), 64'(k % 4));
        end
        check("rr_bal", 64'(balance), 64'({4{10'd736}}));

        // Credit exhaustion and recovery at the refill edge.
        step(1'b0, 16'h0000);
        for (int s = 1; s <= 410; s++) begin
            step(1'b1, 16'h0F00);
            if (s == 50)  check("exhaust_bal", 64'(bal_of(2)), 64'd0);
            if (s == 51)  check("exhaust_grant", 64'(grant), 64'd0);
            if (s == 400) check("refill_bal", 64'(bal_of(2)), 64'd750);
            if (s == 401) begin
                check("resume_grant", 64'(grant), 64'b0100);
                check("resume_bal",   64'(bal_of(2)), 64'd735);
            end
        end

        // Starvation forces a single grant to the low bidder.
        step(1'b0, 16'h0000);
        for (int s = 1; s <= 64; s++) begin
            step(1'b1, 16'h100A);
            if (s == 59) check("starve_pre", 64'(starved), 64'd0);
            if (s == 60) begin
                check("starve_flag", 64'(starved), 64'b1000);
                check("starve_g60",  64'(grant), 64'b0001);
            end
            if (s == 61) begin
                check("starve_force", 64'(grant), 64'b1000);
                check("starve_clr",   64'(starved), 64'd0);
                check("starve_bal3",  64'(bal_of(3)), 64'd749);
            end
            if (s == 62) check("starve_back", 64'(grant), 64'b0001);
        end

        // Saturation at BAL_MAX and grant coinciding with refill.
        step(1'b0, 16'h0000);
        for (int s = 1; s <= 800; s++) begin
            if (s <= 40)       step(1'b1, 16'h00F0);
            else if (s == 400) step(1'b1, 16'h0090);
            else               step(1'b1, 16'h0000);
            if (s == 40) check("sat_pre", 64'(bal_of(1)), 64'd150);
            if (s == 400) begin
                check("sat_bal0",  64'(bal_of(0)), 64'd900);
                check("sat_comb1", 64'(bal_of(1)), 64'd891);
            end
            if (s == 800) begin
                check("sat_hold0", 64'(bal_of(0)), 64'd900);
                check("sat_hold1", 64'(bal_of(1)), 64'd900);
            end
        end

        // Reset during active granting.
        step(1'b0, 16'h0000);
        for (int s = 0; s < 5; s++) step(1'b1, 16'h7777);
        step(1'b0, 16'h7777);
        check("midrst_grant", 64'(grant), 64'd0);
        check("midrst_bal",   64'(balance), 64'({4{10'd750}}));
        step(1'b1, 16'h7777);
        check("midrst_rr",   64'(grant), 64'b0001);
        check("midrst_bal0", 64'(bal_of(0)), 64'd743);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
